// File: rtl/dcache_pkg.sv
// Shared types and address helpers for the direct-mapped data cache.
package dcache_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITEBACK,
        S_FILL_REQ,
        S_FILL_WAIT,
        S_RESPOND
    } state_t;

    localparam int ADDR_BITS = 32;
    localparam int WORD_BITS = 32;

    // Word-offset bits inside a line.
    function automatic int ob_bits(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int ib_bits(input int num_sets);
        return $clog2(num_sets);
    endfunction

    function automatic int tb_bits(input int num_sets, input int line_words);
        return ADDR_BITS - ib_bits(num_sets) - ob_bits(line_words) - 2;
    endfunction

    // Line-aligned byte address from a tag and set index.
    function automatic logic [31:0] line_addr(input logic [31:0] tag, input logic [31:0] index,
                                              input int ib, input int ob);
        return (tag << (ib + ob + 2)) | (index << (ob + 2));
    endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Per-set valid/dirty/tag/data storage: combinational read, synchronous word or line write.
// A word write always marks the line dirty; a line write installs a clean, valid line.
module dcache_line_array
    import dcache_pkg::*;
#(
    parameter int NUM_SETS   = 16,
    parameter int LINE_WORDS = 4,
    localparam int OB = ob_bits(LINE_WORDS),
    localparam int IB = ib_bits(NUM_SETS),
    localparam int TB = tb_bits(NUM_SETS, LINE_WORDS),
    localparam int LW = WORD_BITS * LINE_WORDS
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [IB-1:0] idx,
    output logic          rd_valid,
    output logic          rd_dirty,
    output logic [TB-1:0] rd_tag,
    output logic [LW-1:0] rd_line,
    input  logic          word_we,
    input  logic [OB-1:0] word_off,
    input  logic [31:0]   word_data,
    input  logic          line_we,
    input  logic [TB-1:0] line_tag,
    input  logic [LW-1:0] line_data
);

    logic [NUM_SETS-1:0] valid_q;
    logic [NUM_SETS-1:0] dirty_q;
    logic [TB-1:0]       tag_q  [NUM_SETS];
    logic [LW-1:0]       data_q [NUM_SETS];

    assign rd_valid = valid_q[idx];
    assign rd_dirty = dirty_q[idx];
    assign rd_tag   = tag_q[idx];
    assign rd_line  = data_q[idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (line_we) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
        end else if (word_we) begin
            dirty_q[idx] <= 1'b1;
        end
    end

    // Tags and data are never cleared; valid gates their use.
    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_q[idx]  <= line_tag;
            data_q[idx] <= line_data;
        end else if (word_we) begin
            data_q[idx][{word_off, 5'b0} +: 32] <= word_data;
        end
    end

endmodule

// File: rtl/dcache_direct_mapped.sv
// Direct-mapped write-back/write-allocate data cache; hits respond the cycle after acceptance.
// Misses stall the CPU (cpu_ready low) through an optional writeback, fetch request and fill.
module dcache_direct_mapped
    import dcache_pkg::*;
#(
    parameter int NUM_SETS   = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cpu_req_valid,
    input  logic                    cpu_req_write,
    input  logic [31:0]             cpu_addr,
    input  logic [31:0]             cpu_wdata,
    output logic                    cpu_ready,
    output logic                    cpu_resp_valid,
    output logic [31:0]             cpu_rdata,
    output logic                    cpu_resp_hit,
    output logic                    mem_req,
    output logic                    mem_write,
    output logic [31:0]             mem_addr,
    output logic [32*LINE_WORDS-1:0] mem_wdata,
    input  logic                    mem_ready,
    input  logic                    mem_rdata_valid,
    input  logic [32*LINE_WORDS-1:0] mem_rdata,
    output logic [31:0]             hit_count,
    output logic [31:0]             miss_count
);

    localparam int OB = ob_bits(LINE_WORDS);
    localparam int IB = ib_bits(NUM_SETS);
    localparam int TB = tb_bits(NUM_SETS, LINE_WORDS);
    localparam int LW = WORD_BITS * LINE_WORDS;

    state_t        state;
    logic [31:0]   lat_addr;
    logic [31:0]   lat_wdata;
    logic          lat_write;

    logic [OB-1:0] req_off, lat_off, word_off;
    logic [IB-1:0] req_idx, lat_idx, arr_idx;
    logic [TB-1:0] req_tag, lat_tag, rd_tag;
    logic          rd_valid, rd_dirty;
    logic [LW-1:0] rd_line;
    logic [31:0]   rd_word, word_data;
    logic          accept, is_hit, word_we, line_we;
    logic [31:0]   victim_addr, req_fill_addr, lat_fill_addr;
    logic          unused_bits;

    assign req_off = cpu_addr[OB+1:2];
    assign req_idx = cpu_addr[OB+2 +: IB];
    assign req_tag = cpu_addr[OB+IB+2 +: TB];
    assign lat_off = lat_addr[OB+1:2];
    assign lat_idx = lat_addr[OB+2 +: IB];
    assign lat_tag = lat_addr[OB+IB+2 +: TB];
    assign unused_bits = ^{cpu_addr[1:0], lat_addr[1:0]};

    assign cpu_ready = (state == S_IDLE);
    assign accept    = cpu_req_valid && cpu_ready;
    assign is_hit    = rd_valid && (rd_tag == req_tag);

    // The array port follows the live CPU address while idle, else the latched miss.
    always_comb begin
        arr_idx   = (state == S_IDLE) ? req_idx : lat_idx;
        word_off  = (state == S_IDLE) ? req_off : lat_off;
        word_data = (state == S_IDLE) ? cpu_wdata : lat_wdata;
        word_we   = (accept && is_hit && cpu_req_write) ||
                    ((state == S_RESPOND) && lat_write);
        line_we   = (state == S_FILL_WAIT) && mem_rdata_valid;
    end

    assign rd_word       = rd_line[{word_off, 5'b0} +: 32];
    assign victim_addr   = line_addr(32'(rd_tag), 32'(arr_idx), IB, OB);
    assign req_fill_addr = line_addr(32'(req_tag), 32'(req_idx), IB, OB);
    assign lat_fill_addr = line_addr(32'(lat_tag), 32'(lat_idx), IB, OB);

    dcache_line_array #(
        .NUM_SETS   (NUM_SETS),
        .LINE_WORDS (LINE_WORDS)
    ) u_lines (
        .clk       (clk),
        .reset     (reset),
        .idx       (arr_idx),
        .rd_valid  (rd_valid),
        .rd_dirty  (rd_dirty),
        .rd_tag    (rd_tag),
        .rd_line   (rd_line),
        .word_we   (word_we),
        .word_off  (word_off),
        .word_data (word_data),
        .line_we   (line_we),
        .line_tag  (lat_tag),
        .line_data (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            lat_addr       <= '0;
            lat_wdata      <= '0;
            lat_write      <= 1'b0;
            cpu_resp_valid <= 1'b0;
            cpu_resp_hit   <= 1'b0;
            cpu_rdata      <= '0;
            mem_req        <= 1'b0;
            mem_write      <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            hit_count      <= '0;
            miss_count     <= '0;
        end else begin
            cpu_resp_valid <= 1'b0;
            cpu_resp_hit   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept && is_hit) begin
                        cpu_resp_valid <= 1'b1;
                        cpu_resp_hit   <= 1'b1;
                        if (!cpu_req_write) cpu_rdata <= rd_word;
                        if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
                    end else if (accept) begin
                        lat_addr  <= cpu_addr;
                        lat_wdata <= cpu_wdata;
                        lat_write <= cpu_req_write;
                        mem_req   <= 1'b1;
                        mem_wdata <= rd_line;
                        if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
                        if (rd_valid && rd_dirty) begin
                            mem_write <= 1'b1;
                            mem_addr  <= victim_addr;
                            state     <= S_WRITEBACK;
                        end else begin
                            mem_write <= 1'b0;
                            mem_addr  <= req_fill_addr;
                            state     <= S_FILL_REQ;
                        end
                    end
                end
                S_WRITEBACK: begin
                    // Request stays up; it simply changes into the fetch.
                    if (mem_ready) begin
                        mem_write <= 1'b0;
                        mem_addr  <= lat_fill_addr;
                        state     <= S_FILL_REQ;
                    end
                end
                S_FILL_REQ: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        state   <= S_FILL_WAIT;
                    end
                end
                S_FILL_WAIT: begin
                    if (mem_rdata_valid) state <= S_RESPOND;
                end
                S_RESPOND: begin
                    cpu_resp_valid <= 1'b1;
                    if (!lat_write) cpu_rdata <= rd_word;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/dcache_direct_mapped.md
# dcache_direct_mapped

Direct-mapped, write-back, write-allocate data cache placed between the CPU's memory stage and the data memory. It serves hits from internal line storage and, on a miss, evicts a dirty victim before refilling the line. Backing memory traffic uses a line-wide request/ready handshake with a separate fill-valid strobe, so the backing store may take any number of cycles. It also keeps hit and miss counters for performance reporting.

## Interface
Parameters:
- NUM_SETS, 16: number of lines; power of two, at least 2.
- LINE_WORDS, 4: 32-bit words per line; power of two, at least 2.

Ports:
- clk  in  1  clock; everything updates on the rising edge.
- reset  in  1  synchronous, active-high.
- cpu_req_valid  in  1  CPU access request.
- cpu_req_write  in  1  1 = store, 0 = load.
- cpu_addr  in  32  byte address; bits [1:0] ignored.
- cpu_wdata  in  32  store data.
- cpu_ready  out  1  cache can accept a request this cycle.
- cpu_resp_valid  out  1  one-cycle response strobe.
- cpu_rdata  out  32  load data, valid with cpu_resp_valid.
- cpu_resp_hit  out  1  1 if the response came from a hit.
- mem_req  out  1  memory request.
- mem_write  out  1  1 = writeback, 0 = line fetch.
- mem_addr  out  32  line-aligned byte address.
- mem_wdata  out  32*LINE_WORDS  victim line; word i is at bits [32i+31:32i].
- mem_ready  in  1  memory accepts the request.
- mem_rdata_valid  in  1  fill data valid (one cycle).
- mem_rdata  in  32*LINE_WORDS  fill line, same word ordering.
- hit_count  out  32  accepted hits; saturates at 0xFFFF_FFFF.
- miss_count  out  32  accepted misses; saturates at 0xFFFF_FFFF.

## Operation
- Address fields: word offset = addr[OB+1:2] with OB = log2(LINE_WORDS); index = next log2(NUM_SETS) bits; tag = the remaining upper bits.
- Per line the cache holds valid, dirty, tag, and data.
- States are IDLE, WRITEBACK, FILL_REQ, FILL_WAIT, RESPOND.
- IDLE:
  - cpu_ready = 1. A request is accepted when cpu_req_valid && cpu_ready.
  - Lookup is combinational on cpu_addr.
  - Hit: a load registers the word; a store merges cpu_wdata and sets dirty. Both assert cpu_resp_valid and cpu_resp_hit the next cycle. hit_count increments. State stays IDLE.
  - Miss: latch addr, write flag and wdata. miss_count increments.
  - If the victim is valid and dirty, go to WRITEBACK; otherwise go to FILL_REQ.
- WRITEBACK:
  - Drive mem_req=1, mem_write=1, mem_addr = {victim tag, index, 0}, mem_wdata = victim line.
  - Hold all of these stable until mem_ready is sampled 1, then go to FILL_REQ.
- FILL_REQ:
  - Drive mem_req=1, mem_write=0, mem_addr = latched line address.
  - Hold until mem_ready is sampled 1, then go to FILL_WAIT.
- FILL_WAIT:
  - mem_req=0. On mem_rdata_valid, write the line, set valid=1, dirty=0, and the new tag, then go to RESPOND.
- RESPOND:
  - Perform the latched access against the filled line; a store merges and sets dirty.
  - Assert cpu_resp_valid=1 with cpu_resp_hit=0, then go to IDLE.
- cpu_ready = 0 in every state other than IDLE.
- mem_ready is ignored outside WRITEBACK and FILL_REQ. mem_rdata_valid is ignored outside FILL_WAIT.

## Timing
- Reset values: state IDLE, all valid and dirty bits 0, and both counters 0. Outputs are cpu_ready=1 and 0 for cpu_resp_valid, cpu_rdata, cpu_resp_hit, mem_req, mem_write, mem_addr, mem_wdata. Line data is not cleared.
- Hit latency: request accepted at edge N, response visible during cycle N+1. Back-to-back hits sustain one per cycle.
- Clean miss: cycles = 1 + FILL_REQ wait + FILL_WAIT wait + 1.
- Dirty miss: add the WRITEBACK wait to the clean-miss count.
- Reset takes priority over everything, including mid-miss. The in-flight access is discarded, any pending writeback is lost, and mem_req is 0 in the cycle after reset.
- cpu_resp_valid is high for exactly one cycle per accepted request.

## Structure
- Package dcache_pkg holds:
  - the state enum,
  - localparam helpers for OB, IB (index bits), TB (tag bits),
  - a line-address build function.
- Sub-module dcache_line_array holds valid, dirty, tag, and data arrays. It provides a combinational read port and a synchronous port for word write, line write, and dirty set. The FSM, counters, and handshakes stay in dcache_direct_mapped.

## Test plan
All scenarios use the defaults: index = addr[7:4], tag = addr[31:8].
1. After reset, load 0x40; memory fills {0x11,0x22,0x33,0x44} after 3 cycles. Expect mem_req with mem_write=0 and mem_addr=0x40, no writeback, cpu_rdata=0x11 with cpu_resp_hit=0, miss_count=1.
2. Then load 0x44. Expect a response in the next cycle with cpu_rdata=0x22, cpu_resp_hit=1, hit_count=1.
3. Store 0xDEADBEEF to 0x48 (hit), then load 0x148. Expect WRITEBACK with mem_addr=0x40 and word2=0xDEADBEEF, followed by a fetch with mem_addr=0x140.
4. Hold mem_ready low for 5 cycles during FILL_REQ. Expect mem_req, mem_addr and mem_write stable throughout, cpu_ready=0, and no response.
5. Assert reset while in FILL_WAIT. Expect mem_req=0 and cpu_ready=1 next cycle; a subsequent load of 0x40 misses again.
6. Issue hits on 0x40, 0x44, 0x48, 0x4C on consecutive cycles. Expect cpu_resp_valid for 4 consecutive cycles and hit_count incremented by 4.
